// File: rtl/vproc_div_elem_seq.sv
// Element sequencer in front of vproc_div_block: splits a packed SEW8/SEW16 word into
// per-element divides and repacks the results. Optional out_dz_o via VPROC_DIV_SEQ_DZ_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready_o=1
// ISSUE | one element per cycle driven to the divide block
// DRAIN | waiting for in-flight results (only when DIV_LAT>0)
// OUT   | packed result presented on out_res_o
module vproc_div_elem_seq #(
    parameter int DIV_LAT = 0
) (
    input  logic        clk_i,
    input  logic        async_rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_op1_i,
    input  logic [31:0] in_op2_i,
    input  logic        in_sew_i,
    input  logic        in_signed_i,
    input  logic        in_mod_i,
    output logic        div_mod_o,
    output logic [16:0] div_op1_o,
    output logic [16:0] div_op2_o,
    input  logic [32:0] div_res_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_res_o
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
   ,output logic [3:0]  out_dz_o
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

    typedef struct packed {
        logic        valid;
        logic [1:0]  idx;
        logic        dz;
        logic        ovf;
        logic [15:0] dvd;
    } tag_t;

    state_e      state_q, state_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic        sew_q, sew_d, sgn_q, sgn_d, mod_q, mod_d;
    logic [1:0]  idx_q, idx_d;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    logic [3:0]  dz_q, dz_d;
`endif

    logic [15:0] e1, e2, slot;
    logic [16:0] x1, x2;
    logic        e1_neg, e2_neg, el_dz, el_ovf, issuing, upstream_busy;
    tag_t        issue_tag, cap_tag;
    logic        unused_res;

    assign unused_res = ^div_res_i[32:16];

    always_comb begin
        if (sew_q) begin
            e1     = op1_q[{idx_q[0], 4'b0000} +: 16];
            e2     = op2_q[{idx_q[0], 4'b0000} +: 16];
            e1_neg = sgn_q & e1[15];
            e2_neg = sgn_q & e2[15];
            x1     = {e1_neg, e1};
            x2     = {e2_neg, e2};
            el_dz  = (e2 == 16'h0000);
            el_ovf = sgn_q & (e1 == 16'h8000) & (e2 == 16'hFFFF);
        end else begin
            e1     = {8'h00, op1_q[{idx_q, 3'b000} +: 8]};
            e2     = {8'h00, op2_q[{idx_q, 3'b000} +: 8]};
            e1_neg = sgn_q & e1[7];
            e2_neg = sgn_q & e2[7];
            x1     = {{9{e1_neg}}, e1[7:0]};
            x2     = {{9{e2_neg}}, e2[7:0]};
            el_dz  = (e2[7:0] == 8'h00);
            el_ovf = sgn_q & (e1[7:0] == 8'h80) & (e2[7:0] == 8'hFF);
        end
    end

    assign issuing   = (state_q == ISSUE);
    assign issue_tag = {issuing, idx_q, el_dz, el_ovf, e1};

    // A zero divisor is replaced by 1 so the divide block never sees x/0.
    assign div_op1_o = issuing ? x1 : 17'd0;
    assign div_op2_o = issuing ? (el_dz ? 17'd1 : x2) : 17'd0;
    assign div_mod_o = issuing & mod_q;

    if (DIV_LAT == 0) begin : g_no_tag
        assign cap_tag       = issue_tag;
        assign upstream_busy = 1'b0;
    end else begin : g_tag
        tag_t tag_q [DIV_LAT];
        tag_t tag_d [DIV_LAT];

        always_comb begin
            tag_d[0] = issue_tag;
            for (int i = 1; i < DIV_LAT; i++) tag_d[i] = tag_q[i-1];
        end

        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                for (int i = 0; i < DIV_LAT; i++) tag_q[i] <= '0;
            end else begin
                tag_q <= tag_d;
            end
        end

        // The last stage is captured this cycle, so only earlier stages keep DRAIN busy.
        always_comb begin
            upstream_busy = 1'b0;
            for (int i = 0; i < DIV_LAT - 1; i++) upstream_busy = upstream_busy | tag_q[i].valid;
        end

        assign cap_tag = tag_q[DIV_LAT-1];
    end

    always_comb begin
        slot = sew_q ? div_res_i[15:0] : {8'h00, div_res_i[7:0]};
        if (cap_tag.dz) begin
            slot = mod_q ? cap_tag.dvd : (sew_q ? 16'hFFFF : 16'h00FF);
        end else if (cap_tag.ovf) begin
            slot = mod_q ? 16'h0000 : cap_tag.dvd;
        end
    end

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        sew_d       = sew_q;
        sgn_d       = sgn_q;
        mod_d       = mod_q;
        idx_d       = idx_q;
        res_d       = res_q;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
        dz_d        = dz_q;
`endif
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;

        if (cap_tag.valid) begin
            if (sew_q) res_d[{cap_tag.idx[0], 4'b0000} +: 16] = slot;
            else       res_d[{cap_tag.idx, 3'b000} +: 8]      = slot[7:0];
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
            dz_d[cap_tag.idx] = cap_tag.dz;
`endif
        end

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    op1_d   = in_op1_i;
                    op2_d   = in_op2_i;
                    sew_d   = in_sew_i;
                    sgn_d   = in_signed_i;
                    mod_d   = in_mod_i;
                    idx_d   = 2'd0;
                    res_d   = '0;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
                    dz_d    = '0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == (sew_q ? 2'd1 : 2'd3)) begin
                    idx_d   = 2'd0;
                    state_d = (DIV_LAT == 0) ? OUT : DRAIN;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DRAIN: begin
                if (!upstream_busy) state_d = OUT;
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sew_q   <= 1'b0;
            sgn_q   <= 1'b0;
            mod_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
            dz_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sew_q   <= sew_d;
            sgn_q   <= sgn_d;
            mod_q   <= mod_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign out_res_o = res_q;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    assign out_dz_o  = dz_q;
`endif

endmodule

// File: tb/tb_vproc_div_elem_seq.sv
// Bench for vproc_div_elem_seq: three instances (DIV_LAT 0, 2, 3) share stimulus, each with a
// behavioural divide block and a scoreboard monitor checking result, latency and hold.
module tb_vproc_div_elem_seq;

    localparam int LATS [3] = '{0, 2, 3};

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  dz;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sew, sgn, md, out_ready;
    logic [31:0] op1, op2;

    logic        in_ready  [3];
    logic        out_valid [3];
    logic        div_mod   [3];
    logic [16:0] div_op1   [3];
    logic [16:0] div_op2   [3];
    logic [31:0] out_res   [3];
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    logic [3:0]  out_dz    [3];
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    for (genvar l = 0; l < 3; l++) begin : g_lane
        localparam int LAT = LATS[l];
        localparam int SEL = (LAT == 0) ? 1 : LAT;

        logic [16:0]        p1 [1:3];
        logic [16:0]        p2 [1:3];
        logic               pm [1:3];
        logic signed [16:0] a, b, q, r;
        logic               m;
        logic [32:0]        res_m;

        always @(posedge clk) begin
            p1[1] <= div_op1[l]; p1[2] <= p1[1]; p1[3] <= p1[2];
            p2[1] <= div_op2[l]; p2[2] <= p2[1]; p2[3] <= p2[2];
            pm[1] <= div_mod[l]; pm[2] <= pm[1]; pm[3] <= pm[2];
        end

        // Reference divide block: truncating signed division on the 17-bit operands.
        always_comb begin
            a = (LAT == 0) ? div_op1[l] : p1[SEL];
            b = (LAT == 0) ? div_op2[l] : p2[SEL];
            m = (LAT == 0) ? div_mod[l] : pm[SEL];
            if (b == 17'sd0) begin
                q = '1;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
            res_m = m ? {{16{r[16]}}, r} : {{16{q[16]}}, q};
        end

        vproc_div_elem_seq #(.DIV_LAT(LAT)) u_dut (
            .clk_i       (clk),
            .async_rst_ni(rst_n),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready[l]),
            .in_op1_i    (op1),
            .in_op2_i    (op2),
            .in_sew_i    (sew),
            .in_signed_i (sgn),
            .in_mod_i    (md),
            .div_mod_o   (div_mod[l]),
            .div_op1_o   (div_op1[l]),
            .div_op2_o   (div_op2[l]),
            .div_res_i   (res_m),
            .out_valid_o (out_valid[l]),
            .out_ready_i (out_ready),
            .out_res_o   (out_res[l])
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
           ,.out_dz_o    (out_dz[l])
`endif
        );

        int          acc = 0;
        logic        pv  = 1'b0;
        logic [31:0] held;
        exp_t        e;

        always @(negedge clk) begin
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (in_valid && in_ready[l]) acc = cyc;
                if (out_valid[l]) begin
                    if (pv) begin
                        check($sformatf("L%0d hold_res", l), out_res[l], held);
                        check($sformatf("L%0d hold_rdy", l), {31'b0, in_ready[l]}, 32'h0);
                    end else if (exp_q[l].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL L%0d unexpected_out: got %h want none", l, out_res[l]);
                    end else begin
                        e = exp_q[l][0];
                        check($sformatf("L%0d latency", l), 32'(cyc - acc), 32'(e.lat));
                    end
                    held = out_res[l];
                    if (out_ready && exp_q[l].size() > 0) begin
                        e = exp_q[l].pop_front();
                        check($sformatf("L%0d result", l), out_res[l], e.res);
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
                        check($sformatf("L%0d dz_flag", l), {28'b0, out_dz[l]}, {28'b0, e.dz});
`endif
                    end
                    pv = !out_ready;
                end else begin
                    pv = 1'b0;
                end
            end
        end
    end

    task automatic chk_reset(input string nm);
        for (int l = 0; l < 3; l++) begin
            check({nm, " in_ready"},  {31'b0, in_ready[l]},  32'h1);
            check({nm, " out_valid"}, {31'b0, out_valid[l]}, 32'h0);
            check({nm, " out_res"},   out_res[l],            32'h0);
            check({nm, " div_op1"},   {15'b0, div_op1[l]},   32'h0);
            check({nm, " div_op2"},   {15'b0, div_op2[l]},   32'h0);
            check({nm, " div_mod"},   {31'b0, div_mod[l]},   32'h0);
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
            check({nm, " out_dz"},    {28'b0, out_dz[l]},    32'h0);
`endif
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 300; k++) begin
            if (in_ready[0] && in_ready[1] && in_ready[2]) return;
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $display("FAIL wait_ready: got busy want idle within 300 cycles");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 500; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) begin
                wait_ready();
                return;
            end
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $display("FAIL wait_drain: got %0d/%0d/%0d pending want 0",
                 exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [3:0] dz, input logic s);
        for (int l = 0; l < 3; l++) begin
            exp_t x;
            x.res = res;
            x.dz  = dz;
            x.lat = 8'((s ? 2 : 4) + LATS[l] + 1);
            exp_q[l].push_back(x);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic sg, input logic m, input logic [31:0] res,
                        input logic [3:0] dz, input bit chk_op2);
        wait_ready();
        op1      = a;
        op2      = b;
        sew      = s;
        sgn      = sg;
        md       = m;
        in_valid = 1'b1;
        push_exp(res, dz, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chk_op2) begin
            @(posedge clk); #1;
            for (int l = 0; l < 3; l++) check("dz_op2", {15'b0, div_op2[l]}, 32'h1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op1       = '0;
        op2       = '0;
        sew       = 1'b0;
        sgn       = 1'b0;
        md        = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h80F90764, 32'hFF02FE07, 1'b0, 1'b1, 1'b0, 32'h80FDFD0E, 4'b0000, 1'b0);
        send(32'h80F90764, 32'hFF02FE07, 1'b0, 1'b1, 1'b1, 32'h00FF0102, 4'b0000, 1'b0);
        send(32'h123400FF, 32'h00000010, 1'b1, 1'b0, 1'b0, 32'hFFFF000F, 4'b0010, 1'b1);
        send(32'h123400FF, 32'h00000010, 1'b1, 1'b0, 1'b1, 32'h1234000F, 4'b0010, 1'b1);
        send(32'h8000FFF9, 32'hFFFF0002, 1'b1, 1'b1, 1'b0, 32'h8000FFFD, 4'b0000, 1'b0);
        send(32'h8000FFF9, 32'hFFFF0002, 1'b1, 1'b1, 1'b1, 32'h0000FFFF, 4'b0000, 1'b0);

        // Backpressure with a competing request held on in_valid the whole time.
        wait_drain();
        out_ready = 1'b0;
        send(32'h80F90764, 32'hFF02FE07, 1'b0, 1'b1, 1'b0, 32'h80FDFD0E, 4'b0000, 1'b0);
        op1      = 32'h8000FFF9;
        op2      = 32'hFFFF0002;
        sew      = 1'b1;
        sgn      = 1'b1;
        md       = 1'b0;
        in_valid = 1'b1;
        push_exp(32'h8000FFFD, 4'b0000, 1'b1);
        for (int k = 0; k < 17; k++) begin
            for (int l = 0; l < 3; l++) check("bp_busy", {31'b0, in_ready[l]}, 32'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int l = 0; l < 3; l++) check("bp_last_busy", {31'b0, in_ready[l]}, 32'h0);
        @(posedge clk); #1;
        for (int l = 0; l < 3; l++) check("bp_ready_after", {31'b0, in_ready[l]}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset during cycle t+2 of an SEW8 transaction.
        wait_drain();
        op1      = 32'h12345678;
        op2      = 32'h01010101;
        sew      = 1'b0;
        sgn      = 1'b0;
        md       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h00000009, 32'h00000003, 1'b0, 1'b0, 1'b0, 32'hFFFFFF03, 4'b1110, 1'b0);

        wait_drain();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
